// File: rtl/store_data_queue_pkg.sv
// Shared memory-subsystem definitions: queue depths and entry layouts for the
// store data queue and the load queue that records SDQ markers.
package store_data_queue_pkg;

  localparam int SDQ_ENTRIES = 8;
  localparam int LDQ_ENTRIES = 8;

  // One store: allocated (valid), address/data known (addr_valid), payload.
  typedef struct packed {
    logic        valid;
    logic        addr_valid;
    logic [31:0] addr;
    logic [31:0] data;
  } sdq_entry_t;

  // One load: sdq_marker is the SDQ tail (with wrap bit) seen at dispatch,
  // i.e. the boundary between older and younger stores for this load.
  typedef struct packed {
    logic                          valid;
    logic                          addr_valid;
    logic [31:0]                   addr;
    logic [$clog2(SDQ_ENTRIES):0]  sdq_marker;
  } ldq_entry_t;

endpackage

// File: rtl/store_data_queue.sv
// Store data queue: circular buffer of stores with head (drain), commit and
// tail (dispatch) pointers. Pointers carry an extra wrap bit so full and
// empty are distinguishable and markers order correctly across wraps.
//
// Memory write handshake: mem_req_vld_o is raised only when the head entry
// is committed and has its address; once raised it and the addr/data stay
// stable until mem_req_rdy_i is seen high on a rising edge, at which point
// the store is retired. vld never depends on rdy.
module store_data_queue #(
  parameter int SDQ_ENTRIES = store_data_queue_pkg::SDQ_ENTRIES,
  localparam int IW = $clog2(SDQ_ENTRIES)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          disp_vld_i,
  output logic [IW-1:0] sdq_disp_idx_o,
  output logic [IW:0]   sdq_marker_o,
  output logic [IW:0]   sdq_head_marker_o,
  output logic          sdq_full_o,
  output logic          sdq_empty_o,
  input  logic          exec_vld_i,
  input  logic [IW-1:0] exec_sdq_idx_i,
  input  logic [31:0]   exec_addr_i,
  input  logic [31:0]   exec_data_i,
  input  logic          commit_vld_i,
  output logic          mem_req_vld_o,
  input  logic          mem_req_rdy_i,
  output logic [31:0]   mem_req_addr_o,
  output logic [31:0]   mem_req_data_o
);

  import store_data_queue_pkg::*;

  typedef logic [IW:0] ptr_t;

  sdq_entry_t entries [SDQ_ENTRIES];
  ptr_t       head_q;
  ptr_t       cmt_q;
  ptr_t       tail_q;
  ptr_t       cmt_nxt;
  ptr_t       flush_cnt;
  sdq_entry_t head_entry;
  logic       full;
  logic       empty;
  logic       disp_fire;
  logic       commit_fire;
  logic       drain_fire;
  logic       discard [SDQ_ENTRIES];

  // Occupancy purely from registered pointers.
  assign empty = (head_q == tail_q);
  assign full  = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);

  assign head_entry  = entries[head_q[IW-1:0]];
  assign disp_fire   = disp_vld_i && !full && !flush_i;
  assign commit_fire = commit_vld_i && (cmt_q != tail_q);
  assign drain_fire  = mem_req_vld_o && mem_req_rdy_i;

  // Flush rolls tail back to the commit point including a same-cycle commit.
  assign cmt_nxt   = cmt_q + ptr_t'(commit_fire);
  assign flush_cnt = tail_q - cmt_nxt;

  assign sdq_disp_idx_o    = tail_q[IW-1:0];
  assign sdq_marker_o      = tail_q;
  assign sdq_head_marker_o = head_q;
  assign sdq_full_o        = full;
  assign sdq_empty_o       = empty;

  // Only committed entries with a known address may go to memory.
  assign mem_req_vld_o  = (head_q != cmt_q) && head_entry.valid && head_entry.addr_valid;
  assign mem_req_addr_o = head_entry.addr;
  assign mem_req_data_o = head_entry.data;

  // Mark the uncommitted entries [cmt_nxt, tail) that a flush throws away.
  always_comb begin
    for (int i = 0; i < SDQ_ENTRIES; i++) begin
      discard[i] = flush_i && ({1'b0, IW'(i) - cmt_nxt[IW-1:0]} < flush_cnt);
    end
  end

  // Pointer update: drain, commit and dispatch/flush all act in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_q + ptr_t'(drain_fire);
      cmt_q  <= cmt_nxt;
      tail_q <= flush_i ? cmt_nxt : (tail_q + ptr_t'(disp_fire));
    end
  end

  // Entry storage: allocate, then execute write (may hit the entry being
  // allocated), then retire the drained head, then clear flushed entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SDQ_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (disp_fire) begin
        entries[tail_q[IW-1:0]].valid      <= 1'b1;
        entries[tail_q[IW-1:0]].addr_valid <= 1'b0;
      end
      if (exec_vld_i && !flush_i) begin
        entries[exec_sdq_idx_i].addr       <= exec_addr_i;
        entries[exec_sdq_idx_i].data       <= exec_data_i;
        entries[exec_sdq_idx_i].addr_valid <= 1'b1;
      end
      if (drain_fire) begin
        entries[head_q[IW-1:0]].valid      <= 1'b0;
        entries[head_q[IW-1:0]].addr_valid <= 1'b0;
      end
      for (int i = 0; i < SDQ_ENTRIES; i++) begin
        if (discard[i]) begin
          entries[i].valid      <= 1'b0;
          entries[i].addr_valid <= 1'b0;
        end
      end
    end
  end

endmodule
